mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 Opcode  input  6  instruction opcode field from the instruction register.
REQ-005 MemReady  input  1  memory handshake; high means the current read or write completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 ALUSrcB, PCSource, ALUOp  output  2 each  select and op codes; ALUSrcB and PCSource drive 3:1 select muxes.
REQ-008 State  output  4  current FSM state, for debug.

Function
REQ-009 SHALL be a Moore FSM: all outputs decode from the registered state, plus MemReady gating where stated; Opcode affects only next state.
REQ-010 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 are unused.
REQ-011 Opcodes SHALL be: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
REQ-012 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite equal MemReady. FETCH SHALL hold while MemReady=0 and go to DECODE when MemReady=1.
REQ-013 DECODE outputs: ALUSrcA=0, ALUSrcB=10, ALUOp=00.
REQ-014 DECODE next state: LW or SW -> MEMADR; RTYPE -> EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDIEX; any other opcode -> FETCH, with no write enable asserted.
REQ-015 MEMADR outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: LW -> MEMRD, SW -> MEMWR, using the Opcode sampled at this cycle.
REQ-016 MEMRD outputs: MemRead=1, IorD=1. SHALL hold until MemReady=1, then go to MEMWB.
REQ-017 MEMWB outputs: RegWrite=1, MemtoReg=1, RegDst=0. Next state is FETCH.
REQ-018 MEMWR outputs: MemWrite=1, IorD=1. SHALL hold until MemReady=1, then go to FETCH.
REQ-019 EXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is RTYPEWB.
REQ-020 RTYPEWB outputs: RegWrite=1, RegDst=1, MemtoReg=0. Next state is FETCH.
REQ-021 BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state is FETCH.
REQ-022 JUMP outputs: PCWrite=1, PCSource=10. Next state is FETCH.
REQ-023 ADDIEX outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is ADDIWB.
REQ-024 ADDIWB outputs: RegWrite=1, RegDst=0, MemtoReg=0. Next state is FETCH.
REQ-025 Any output not listed for a state SHALL be 0. ALUSrcB and PCSource SHALL never drive 11.
REQ-026 Unused codes 12-15 SHALL drive all outputs to 0 and go to FETCH on the next edge.
REQ-027 Instruction cycle counts (MemReady always 1): LW=5, SW=4, RTYPE=4, ADDI=4, BEQ=3, J=3, illegal=2.

Reset
REQ-028 On a rising CLK edge with RST=1, State SHALL become FETCH regardless of current state, including mid-instruction and mid-wait.
REQ-029 While RST=1, PCWrite, PCWriteCond, MemWrite, RegWrite and IRWrite SHALL be forced to 0 combinationally.
REQ-030 Once reset is released, the first cycle SHALL show FETCH outputs.

Verification
REQ-031 LW, MemReady=1 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-032 SW with MemReady=0 for 3 cycles in MEMWR -> State holds at 5 for 4 cycles; MemWrite=1 throughout; then State=0.
REQ-033 BEQ -> States 0,1,8; in state 8 PCWriteCond=1, PCSource=01, ALUOp=01.
REQ-034 J -> States 0,1,9; in state 9 PCWrite=1, PCSource=10. Opcode=111111 -> States 0,1,0 with all write enables 0 in state 1.
REQ-035 RST=1 asserted while in MEMRD -> next State=0; write enables 0 during reset; FETCH outputs appear after release.
REQ-036 FETCH with MemReady=0 for 2 cycles -> IRWrite=0 and PCWrite=0 while waiting, both 1 on the MemReady=1 cycle, then State=1.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle datapath controller: Moore FSM that sequences fetch, decode,
// memory, execute and write-back steps for a small MIPS-like instruction set.
module mc_control (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t r_state;
  state_t w_next;

  logic       w_pcWrite;
  logic       w_pcWriteCond;
  logic       w_memWrite;
  logic       w_irWrite;
  logic       w_regWrite;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH;
        endcase
      end
      // The opcode is re-sampled here; anything but LW/SW abandons the access.
      S_MEMADR: begin
        case (Opcode)
          OP_LW:   w_next = S_MEMRD;
          OP_SW:   w_next = S_MEMWR;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMRD:   w_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:    w_next = S_RTYPEWB;
      S_RTYPEWB: w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_regWrite    = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALUOp         = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        w_irWrite = MemReady;
        w_pcWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        w_regWrite = 1'b1;
        MemtoReg   = 1'b1;
      end
      S_MEMWR: begin
        w_memWrite = 1'b1;
        IorD       = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RTYPEWB: begin
        w_regWrite = 1'b1;
        RegDst     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        w_pcWriteCond = 1'b1;
        PCSource      = 2'b01;
      end
      S_JUMP: begin
        w_pcWrite = 1'b1;
        PCSource  = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        w_regWrite = 1'b1;
      end
      default: begin
        w_pcWrite = 1'b0;
      end
    endcase
  end

  // Architectural write strobes are killed immediately while reset is held.
  always_comb begin
    PCWrite     = w_pcWrite     & ~RST;
    PCWriteCond = w_pcWriteCond & ~RST;
    MemWrite    = w_memWrite    & ~RST;
    IRWrite     = w_irWrite     & ~RST;
    RegWrite    = w_regWrite    & ~RST;
  end

  assign State = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed instruction scenarios followed by
// random opcode/MemReady/reset traffic, compared against a route-table model.
module tb_mc_control;

  logic       CLK;
  logic       RST;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ILL  = 6'b111111;

  mc_control dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output vector layout:
  // [15]PCWrite [14]PCWriteCond [13]IorD [12]MemRead [11]MemWrite [10]IRWrite
  // [9]MemtoReg [8]RegDst [7]RegWrite [6]ALUSrcA [5:4]ALUSrcB [3:2]PCSource [1:0]ALUOp
  logic [15:0] outTab [16];
  int          expState;
  int          route[$];
  logic [5:0]  opcList [6];

  function automatic logic [15:0] mk(input bit pcw, input bit pcwc, input bit iord,
                                     input bit mrd, input bit mwr, input bit irw,
                                     input bit m2r, input bit rdst, input bit rw,
                                     input bit asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [1:0] aop);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop};
  endfunction

  function automatic logic [15:0] expectedOutputs(input int st, input bit mr, input bit rst);
    logic [15:0] v;
    v = outTab[st];
    if (st == 0) begin
      v[15] = mr;
      v[10] = mr;
    end
    if (rst) begin
      v[15] = 1'b0;
      v[14] = 1'b0;
      v[11] = 1'b0;
      v[10] = 1'b0;
      v[7]  = 1'b0;
    end
    return v;
  endfunction

  // Advance the model: instructions are routes of states chosen at DECODE;
  // FETCH, MEMRD and MEMWR wait for MemReady before moving on.
  task automatic advanceModel(input bit rst, input logic [5:0] opc, input bit mr);
    if (rst) begin
      expState = 0;
      route.delete();
    end else if ((expState == 0 || expState == 3 || expState == 5) && !mr) begin
      expState = expState;
    end else if (expState == 0) begin
      expState = 1;
    end else begin
      if (expState == 1) begin
        route.delete();
        if (opc == LW)        route = '{2, 3, 4};
        else if (opc == SW)   route = '{2, 5};
        else if (opc == RT)   route = '{6, 7};
        else if (opc == BEQ)  route = '{8};
        else if (opc == JMP)  route = '{9};
        else if (opc == ADDI) route = '{10, 11};
      end
      if (route.size() > 0) expState = route.pop_front();
      else                  expState = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input int want);
    logic [15:0] obs;
    logic [15:0] exp;
    obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};
    exp = expectedOutputs(expState, MemReady, RST);
    total++;
    assert (State === 4'(expState)) else begin
      bad++;
      $error("[TB] FAIL %s-state observed=%0d expected=%0d", tag, State, expState);
    end
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s-outputs observed=%h expected=%h (state %0d)", tag, obs, exp, expState);
    end
    if (want >= 0) begin
      total++;
      assert (State === 4'(want)) else begin
        bad++;
        $error("[TB] FAIL %s-seq observed=%0d expected=%0d", tag, State, want);
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input bit rst, input logic [5:0] opc,
                               input bit mr, input int want);
    @(negedge CLK);
    RST      = rst;
    Opcode   = opc;
    MemReady = mr;
    #1;
    checkOutput(tag, want);
    advanceModel(rst, opc, mr);
  endtask

  initial begin
    outTab[0]  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
    outTab[1]  = mk(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00);
    outTab[2]  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    outTab[3]  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    outTab[4]  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
    outTab[5]  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
    outTab[6]  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10);
    outTab[7]  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    outTab[8]  = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
    outTab[9]  = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00);
    outTab[10] = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    outTab[11] = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
    for (int i = 12; i < 16; i++) outTab[i] = 16'h0000;
    opcList = '{LW, SW, RT, BEQ, JMP, ADDI};

    RST = 1'b1; Opcode = 6'd0; MemReady = 1'b0;
    expState = 0;
    repeat (2) @(posedge CLK);

    // Reset held: FETCH with strobes forced low even when MemReady is high.
    applyStimulus("rst-hold", 1, RT, 1, 0);
    applyStimulus("rst-hold2", 1, RT, 0, 0);

    // LW with MemReady high: 0,1,2,3,4,0
    applyStimulus("lw0", 0, LW, 1, 0);
    applyStimulus("lw1", 0, LW, 1, 1);
    applyStimulus("lw2", 0, LW, 1, 2);
    applyStimulus("lw3", 0, LW, 1, 3);
    applyStimulus("lw4", 0, LW, 1, 4);
    applyStimulus("lw5", 0, LW, 1, 0);

    // SW stalled three cycles in MEMWR.
    applyStimulus("sw1", 0, SW, 1, 1);
    applyStimulus("sw2", 0, SW, 1, 2);
    applyStimulus("sw5a", 0, SW, 0, 5);
    applyStimulus("sw5b", 0, SW, 0, 5);
    applyStimulus("sw5c", 0, SW, 0, 5);
    applyStimulus("sw5d", 0, SW, 1, 5);

    // FETCH stall two cycles, then J: 0,0,0,1,9,0
    applyStimulus("fw0a", 0, JMP, 0, 0);
    applyStimulus("fw0b", 0, JMP, 0, 0);
    applyStimulus("fw0c", 0, JMP, 1, 0);
    applyStimulus("j1", 0, JMP, 1, 1);
    applyStimulus("j9", 0, JMP, 1, 9);

    // BEQ, illegal opcode, RTYPE, ADDI
    applyStimulus("beq0", 0, BEQ, 1, 0);
    applyStimulus("beq1", 0, BEQ, 1, 1);
    applyStimulus("beq8", 0, BEQ, 1, 8);
    applyStimulus("ill0", 0, ILL, 1, 0);
    applyStimulus("ill1", 0, ILL, 1, 1);
    applyStimulus("ill2", 0, ILL, 1, 0);
    applyStimulus("rt1", 0, RT, 1, 1);
    applyStimulus("rt6", 0, RT, 1, 6);
    applyStimulus("rt7", 0, RT, 1, 7);
    applyStimulus("ad0", 0, ADDI, 1, 0);
    applyStimulus("ad1", 0, ADDI, 1, 1);
    applyStimulus("ad10", 0, ADDI, 1, 10);
    applyStimulus("ad11", 0, ADDI, 1, 11);

    // Reset asserted while waiting in MEMRD.
    applyStimulus("rr0", 0, LW, 1, 0);
    applyStimulus("rr1", 0, LW, 1, 1);
    applyStimulus("rr2", 0, LW, 1, 2);
    applyStimulus("rr3", 0, LW, 0, 3);
    applyStimulus("rr3rst", 1, LW, 0, 3);
    applyStimulus("rrfetch", 0, LW, 1, 0);
    applyStimulus("rrdec", 0, LW, 1, 1);

    // Random traffic; opcode only changes while the model is in FETCH.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] opc;
      bit         rst;
      bit         mr;
      int         k;
      opc = Opcode;
      if (expState == 0) begin
        k = $urandom_range(6, 0);
        if (k == 6) opc = 6'($urandom);
        else        opc = opcList[k];
      end
      rst = ($urandom_range(39, 0) == 0);
      mr  = ($urandom_range(3, 0) != 0);
      applyStimulus("rand", rst, opc, mr, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
